// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port unified memory between the fetch stage (instruction
// port) and the load/store unit (data port). One access is outstanding at a time. Read data
// is returned to the owning requester MEM_LATENCY cycles after the grant. A fetch redirect
// (if_flush) discards the response of an outstanding fetch.
//
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//   defined   -> starvation counter; fetch wins once it has lost STARVE_LIMIT arbitrations in a row
//   undefined -> strict LSU priority; fetch is granted only when lsu_req is low
//
// Parameters:
//   MEM_LATENCY  - cycles from mem_req to valid mem_rdata (1..4)
//   STARVE_LIMIT - lost arbitrations before fetch is forced to win (1..15)
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   if_req/if_addr/if_flush          - fetch read request, word address, redirect
//   if_gnt/if_rvalid/if_rdata        - fetch grant, response pulse, instruction
//   lsu_req/we/addr/wdata/be         - LSU request and command fields
//   lsu_gnt/lsu_rvalid/lsu_rdata     - LSU grant, response pulse, load data (0 for stores)
//   mem_req/we/addr/wdata/be         - memory command, valid in the grant cycle only
//   mem_rdata                        - memory read data
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_be,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    // Elaboration-time legality checks on the parameters.
    if (MEM_LATENCY == 0 || MEM_LATENCY > 4) begin : gen_bad_latency
        $error("mem_arbiter: MEM_LATENCY must be 1..4");
    end
    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : gen_bad_starve_limit
        $error("mem_arbiter: STARVE_LIMIT must be 1..15");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q;
    logic        owner_lsu_q;  // 1: LSU owns the outstanding access, 0: fetch
    logic        store_q;      // outstanding LSU access is a store
    logic        cancel_q;     // outstanding fetch response is to be dropped
    logic [2:0]  cnt_q;        // cycles left until the response returns

    logic resp;        // response of the outstanding access returns this cycle
    logic arb;         // arbitration allowed this cycle
    logic starve_hit;  // fetch overrides LSU priority this cycle
    logic if_win;
    logic lsu_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    always_comb begin
        starve_hit = if_req && lsu_req && (starve_cnt >= 4'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (if_win) begin
            starve_cnt <= 4'd0;
        end else if (lsu_win && if_req && starve_cnt != 4'd15) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    always_comb begin
        starve_hit = 1'b0;
    end
`endif

    always_comb begin
        resp    = (state_q == StBusy) && (cnt_q == 3'd1);
        arb     = !rst && ((state_q == StIdle) || resp);
        lsu_win = arb && lsu_req && !starve_hit;
        if_win  = arb && if_req && (!lsu_req || starve_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_lsu_q <= 1'b0;
            store_q     <= 1'b0;
            cancel_q    <= 1'b0;
            cnt_q       <= 3'd0;
        end else if (if_win || lsu_win) begin
            // New grant; may overlap the response cycle of the previous access.
            state_q     <= StBusy;
            owner_lsu_q <= lsu_win;
            store_q     <= lsu_win && lsu_we;
            cancel_q    <= if_win && if_flush;
            cnt_q       <= 3'(MEM_LATENCY);
        end else if (resp) begin
            state_q     <= StIdle;
            owner_lsu_q <= 1'b0;
            store_q     <= 1'b0;
            cancel_q    <= 1'b0;
            cnt_q       <= 3'd0;
        end else if (state_q == StBusy) begin
            cnt_q <= cnt_q - 3'd1;
            if (!owner_lsu_q && if_flush) begin
                cancel_q <= 1'b1;
            end
        end
    end

    always_comb begin
        if_gnt  = if_win;
        lsu_gnt = lsu_win;

        // A redirect in the response cycle itself also drops the stale fetch word.
        if_rvalid  = !rst && resp && !owner_lsu_q && !cancel_q && !if_flush;
        if_rdata   = if_rvalid ? mem_rdata : 32'd0;
        lsu_rvalid = !rst && resp && owner_lsu_q;
        lsu_rdata  = (lsu_rvalid && !store_q) ? mem_rdata : 32'd0;

        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_be    = 4'd0;
        if (lsu_win) begin
            mem_req   = 1'b1;
            mem_we    = lsu_we;
            mem_addr  = lsu_addr;
            mem_wdata = lsu_wdata;
            mem_be    = lsu_be;
        end else if (if_win) begin
            mem_req   = 1'b1;
            mem_addr  = if_addr;
            mem_be    = 4'hF;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances at MEM_LATENCY 1, 2 and 3 share one stimulus bus,
// each with its own latency-matched memory model returning mem_word(addr).
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_req, if_flush, lsu_req, lsu_we;
    logic [31:0] if_addr, lsu_addr, lsu_wdata;
    logic [3:0]  lsu_be;

    logic        if_gnt_a [3], if_rvalid_a [3], lsu_gnt_a [3], lsu_rvalid_a [3];
    logic        mem_req_a [3], mem_we_a [3];
    logic [31:0] if_rdata_a [3], lsu_rdata_a [3], mem_addr_a [3], mem_wdata_a [3];
    logic [31:0] mem_rdata_a [3];
    logic [3:0]  mem_be_a [3];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int unsigned Lat = g + 1;
        logic [31:0] pa [4];
        logic        pv [4];

        mem_arbiter #(.MEM_LATENCY(Lat), .STARVE_LIMIT(4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_flush  (if_flush),
            .if_gnt    (if_gnt_a[g]),
            .if_rvalid (if_rvalid_a[g]),
            .if_rdata  (if_rdata_a[g]),
            .lsu_req   (lsu_req),
            .lsu_we    (lsu_we),
            .lsu_addr  (lsu_addr),
            .lsu_wdata (lsu_wdata),
            .lsu_be    (lsu_be),
            .lsu_gnt   (lsu_gnt_a[g]),
            .lsu_rvalid(lsu_rvalid_a[g]),
            .lsu_rdata (lsu_rdata_a[g]),
            .mem_req   (mem_req_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_be    (mem_be_a[g]),
            .mem_rdata (mem_rdata_a[g])
        );

        // Memory model: data for a request appears Lat cycles later, independent of reset.
        always @(posedge clk) begin
            pv[0] <= mem_req_a[g];
            pa[0] <= mem_addr_a[g];
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
        assign mem_rdata_a[g] = pv[Lat-1] ? mem_word(pa[Lat-1]) : 32'hBAD0_BAD0;
    end

    typedef struct {
        int          sel;
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        if_flush, lsu_req, lsu_we;
        logic [31:0] lsu_addr, lsu_wdata;
        logic [3:0]  lsu_be;
        logic        e_if_gnt, e_lsu_gnt, e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_lsu_rvalid;
        logic [31:0] e_lsu_rdata;
        logic        e_mem_req, e_mem_we;
        logic [31:0] e_mem_addr, e_mem_wdata;
        logic [3:0]  e_mem_be;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic setin(input logic r, input logic ireq, input logic [31:0] iaddr,
                         input logic flush, input logic lreq, input logic lwe,
                         input logic [31:0] laddr, input logic [31:0] lwd, input logic [3:0] lbe);
        rst = r; if_req = ireq; if_addr = iaddr; if_flush = flush;
        lsu_req = lreq; lsu_we = lwe; lsu_addr = laddr; lsu_wdata = lwd; lsu_be = lbe;
    endtask

    task automatic idle();
        setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        cyc();
        setin(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cyc();
        idle();
    endtask

    initial begin
        setin(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Field order: sel, rst, if_req, if_addr, if_flush, lsu_req, lsu_we, lsu_addr, lsu_wdata,
        // lsu_be | if_gnt, lsu_gnt, if_rvalid, if_rdata, lsu_rvalid, lsu_rdata, mem_req, mem_we,
        // mem_addr, mem_wdata, mem_be
        // Latency 1: reset, then continuous fetch 0x00, 0x04, 0x08.
        vecs[0]  = '{0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[1]  = '{0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF};
        vecs[2]  = '{0, 1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b1, 1'b0, 1'b1, mem_word(32'h0), 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0,
                     4'hF};
        vecs[3]  = '{0, 1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b1, 1'b0, 1'b1, mem_word(32'h4), 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0,
                     4'hF};
        vecs[4]  = '{0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b0, 1'b0, 1'b1, mem_word(32'h8), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     4'h0};
        vecs[5]  = '{0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        // Latency 2: store wins over concurrent fetch; fetch granted in the response cycle.
        vecs[6]  = '{1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[7]  = '{1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF,
                     1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF,
                     4'hF};
        vecs[8]  = '{1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[9]  = '{1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF};
        vecs[10] = '{1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[11] = '{1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                     1'b0, 1'b0, 1'b1, mem_word(32'h40), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                     4'h0};

        for (int i = 0; i < NV; i++) begin
            int s;
            cyc();
            s = vecs[i].sel;
            setin(vecs[i].rst, vecs[i].if_req, vecs[i].if_addr, vecs[i].if_flush,
                  vecs[i].lsu_req, vecs[i].lsu_we, vecs[i].lsu_addr, vecs[i].lsu_wdata,
                  vecs[i].lsu_be);
            #1;
            chk($sformatf("v%0d if_gnt", i), 32'(if_gnt_a[s]), 32'(vecs[i].e_if_gnt));
            chk($sformatf("v%0d lsu_gnt", i), 32'(lsu_gnt_a[s]), 32'(vecs[i].e_lsu_gnt));
            chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid_a[s]), 32'(vecs[i].e_if_rvalid));
            chk($sformatf("v%0d if_rdata", i), if_rdata_a[s], vecs[i].e_if_rdata);
            chk($sformatf("v%0d lsu_rvalid", i), 32'(lsu_rvalid_a[s]),
                32'(vecs[i].e_lsu_rvalid));
            chk($sformatf("v%0d lsu_rdata", i), lsu_rdata_a[s], vecs[i].e_lsu_rdata);
            chk($sformatf("v%0d mem_req", i), 32'(mem_req_a[s]), 32'(vecs[i].e_mem_req));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we_a[s]), 32'(vecs[i].e_mem_we));
            chk($sformatf("v%0d mem_addr", i), mem_addr_a[s], vecs[i].e_mem_addr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata_a[s], vecs[i].e_mem_wdata);
            chk($sformatf("v%0d mem_be", i), 32'(mem_be_a[s]), 32'(vecs[i].e_mem_be));
        end

        // Starvation, latency 1: both request every cycle.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            logic exp_f;
            cyc();
            setin(1'b0, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
            #1;
            exp_f = Guard && (k % 5 == 4);
            chk($sformatf("starve%0d if_gnt", k), 32'(if_gnt_a[0]), 32'(exp_f));
            chk($sformatf("starve%0d lsu_gnt", k), 32'(lsu_gnt_a[0]), 32'(!exp_f));
        end

        // Flush of an outstanding fetch, latency 2.
        do_reset();
        cyc(); setin(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        chk("flush grant", 32'(if_gnt_a[1]), 32'd1);
        chk("flush grant addr", mem_addr_a[1], 32'h10);
        cyc(); idle(); if_flush = 1'b1; #1;
        chk("flush busy gnt", 32'(if_gnt_a[1]), 32'd0);
        cyc(); setin(1'b0, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #1;
        chk("flush dropped rvalid", 32'(if_rvalid_a[1]), 32'd0);
        chk("flush next gnt", 32'(if_gnt_a[1]), 32'd1);
        chk("flush next addr", mem_addr_a[1], 32'hA0);
        cyc(); idle(); #1;
        chk("flush next early", 32'(if_rvalid_a[1]), 32'd0);
        cyc(); idle(); #1;
        chk("flush next rvalid", 32'(if_rvalid_a[1]), 32'd1);
        chk("flush next rdata", if_rdata_a[1], mem_word(32'hA0));

        // Reset one cycle after an LSU load grant, latency 3.
        do_reset();
        cyc(); setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF); #1;
        chk("rst load gnt", 32'(lsu_gnt_a[2]), 32'd1);
        cyc(); setin(1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 32'h304, 32'h0, 4'hF); #1;
        chk("rst lsu_gnt", 32'(lsu_gnt_a[2]), 32'd0);
        chk("rst if_gnt", 32'(if_gnt_a[2]), 32'd0);
        chk("rst mem_req", 32'(mem_req_a[2]), 32'd0);
        chk("rst mem_addr", mem_addr_a[2], 32'h0);
        chk("rst mem_be", 32'(mem_be_a[2]), 32'd0);
        for (int k = 0; k < 2; k++) begin
            cyc(); idle(); #1;
            chk($sformatf("rst dropped rvalid%0d", k), 32'(lsu_rvalid_a[2]), 32'd0);
        end
        cyc(); setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h304, 32'h0, 4'hF); #1;
        chk("rst regrant", 32'(lsu_gnt_a[2]), 32'd1);
        chk("rst regrant addr", mem_addr_a[2], 32'h304);
        for (int k = 0; k < 2; k++) begin
            cyc(); idle(); #1;
            chk($sformatf("rst regrant wait%0d", k), 32'(lsu_rvalid_a[2]), 32'd0);
        end
        cyc(); idle(); #1;
        chk("rst regrant rvalid", 32'(lsu_rvalid_a[2]), 32'd1);
        chk("rst regrant rdata", lsu_rdata_a[2], mem_word(32'h304));

        // Back-to-back loads, latency 3.
        do_reset();
        cyc(); setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF); #1;
        chk("b2b gnt0", 32'(lsu_gnt_a[2]), 32'd1);
        for (int k = 0; k < 2; k++) begin
            cyc(); setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 4'hF); #1;
            chk($sformatf("b2b wait%0d gnt", k), 32'(lsu_gnt_a[2]), 32'd0);
        end
        cyc(); setin(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h204, 32'h0, 4'hF); #1;
        chk("b2b rvalid0", 32'(lsu_rvalid_a[2]), 32'd1);
        chk("b2b rdata0", lsu_rdata_a[2], mem_word(32'h200));
        chk("b2b gnt1", 32'(lsu_gnt_a[2]), 32'd1);
        chk("b2b addr1", mem_addr_a[2], 32'h204);
        for (int k = 0; k < 2; k++) begin
            cyc(); idle(); #1;
            chk($sformatf("b2b wait1_%0d", k), 32'(lsu_rvalid_a[2]), 32'd0);
        end
        cyc(); idle(); #1;
        chk("b2b rvalid1", 32'(lsu_rvalid_a[2]), 32'd1);
        chk("b2b rdata1", lsu_rdata_a[2], mem_word(32'h204));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port unified memory between the fetch stage (instruction port) and the load/store unit (data port). Issues one memory access at a time, returns read data to the owning requester after a fixed memory latency, and discards in-flight fetch responses when the fetch stage redirects on a taken branch. It sits between `fetch_stage`/LSU and the memory instance.

## Interface
- `MEM_LATENCY`, 1: cycles from memory request to `mem_rdata` valid (legal 1..4)
- `STARVE_LIMIT`, 4: consecutive lost arbitrations after which the fetch port wins (legal 1..15)
- `clk` in 1: the single clock; all state updates on its rising edge
- `rst` in 1: synchronous, active-high reset
- `if_req` in 1: fetch read request; `if_addr` held stable until `if_gnt`
- `if_addr` in 32: fetch word address
- `if_flush` in 1: fetch redirect (taken branch); cancels the outstanding fetch response
- `if_gnt` out 1: fetch request accepted this cycle
- `if_rvalid` out 1: one-cycle pulse, `if_rdata` valid
- `if_rdata` out 32: fetched instruction
- `lsu_req` in 1: data request; `lsu_we`/`lsu_addr`/`lsu_wdata`/`lsu_be` held stable until `lsu_gnt`
- `lsu_we` in 1: 1 = store, 0 = load
- `lsu_addr` in 32, `lsu_wdata` in 32, `lsu_be` in 4: store address/data/byte enables
- `lsu_gnt` out 1: data request accepted this cycle
- `lsu_rvalid` out 1: one-cycle pulse; load data valid, or store completion
- `lsu_rdata` out 32: load data; 0 for stores
- `mem_req`, `mem_we` out 1; `mem_addr`, `mem_wdata` out 32; `mem_be` out 4: memory command
- `mem_rdata` in 32: memory read data, valid `MEM_LATENCY` cycles after `mem_req`

## Operation
- FSM states: IDLE, BUSY. Reset state IDLE; at most one access outstanding.
- Arbitration happens only in IDLE, or in BUSY during the cycle the response returns (back-to-back issue).
- Winner selection: LSU has priority; fetch wins if `lsu_req`=0, or when `starve_cnt` ≥ `STARVE_LIMIT` and both request.
- `starve_cnt` (4 bits): +1 on each arbitration where both request and LSU wins; cleared on any fetch grant; saturates at 15.
- On grant: exactly one of `if_gnt`/`lsu_gnt` high; `mem_req`=1 with the winner's fields driven combinationally the same cycle; fetch grants drive `mem_we`=0, `mem_be`=4'hF, `mem_wdata`=0. Owner tag and latency counter captured; FSM enters BUSY.
- BUSY: counter counts down from `MEM_LATENCY`; at expiry the owner's `rvalid` pulses for one cycle with `rdata`=`mem_rdata` (LSU stores: `lsu_rdata`=0). FSM returns to IDLE unless a new grant is issued that same cycle.
- `if_flush`: if a fetch access is outstanding (granted, response not yet delivered), a cancel bit is set and the response cycle produces no `if_rvalid`; the memory cycle still completes. `if_flush` in the grant cycle of a fetch cancels that fetch. `if_flush` has no effect on LSU accesses or when nothing is outstanding.
- Outputs when idle: all `gnt`, `rvalid`, `mem_req` low; `mem_*` data/address 0; `rdata` 0 when `rvalid` low.

## Timing
- Grant at cycle T: `mem_req` high at T; `rvalid` at T+`MEM_LATENCY`; earliest next grant at T+`MEM_LATENCY`. Peak throughput one access per `MEM_LATENCY` cycles.
- Grant is combinational from `req` in an arbitration cycle; requester must not rely on `gnt` before setting `req`.
- Reset (any cycle, including mid-access): next cycle FSM IDLE, counter and `starve_cnt` 0, cancel bit 0, owner cleared; pending response is dropped (no `rvalid`). All outputs 0 while `rst` high.
- Simultaneous `lsu_req`, `if_req`, and response return: response delivered to old owner and new grant issued in the same cycle.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN`: defined → starvation counter and fetch-wins rule as above. Undefined → strict LSU priority, `starve_cnt` not implemented; fetch is granted only when `lsu_req`=0.

## Test plan
- Reset, `MEM_LATENCY`=1: `if_req`=1 `if_addr`=0x00 → `if_gnt` at T, `mem_addr`=0x00, `if_rvalid` at T+1 with `if_rdata`=memory word 0; continuous fetch yields one word per cycle (0x00, 0x04, 0x08).
- `MEM_LATENCY`=2: `lsu_req` store 0xDEADBEEF to 0x100 `be`=4'hF, concurrent `if_req` → LSU granted first, `lsu_rvalid` at T+2, `lsu_rdata`=0; fetch granted at T+2.
- Guard enabled, `STARVE_LIMIT`=4: both request continuously → LSU wins 4 arbitrations, fifth grant goes to fetch, then LSU again; guard disabled → fetch never granted.
- Fetch granted to 0x10, `if_flush` at T+1 with `MEM_LATENCY`=2 → no `if_rvalid` at T+2; fetch to 0xA0 granted at T+2 returns `if_rvalid` at T+4.
- `rst` asserted one cycle after an LSU load grant → no `lsu_rvalid`, all outputs 0, next request granted from IDLE normally.
- Back-to-back LSU loads 0x200, 0x204 at `MEM_LATENCY`=3 → `lsu_gnt` at T and T+3, `lsu_rvalid` at T+3 and T+6 with matching data.
